// File: rtl/sn_to_bin_if.sv
// Handshake/data bundle between a stochastic stream source and the sn_to_bin decoder.
interface sn_to_bin_if #(parameter int WIDTH = 7);
  logic           start;
  logic           abort;
  logic           sn_in;
  logic           busy;
  logic           valid;
  logic [WIDTH:0] result;

  modport master (output start, output abort, output sn_in,
                  input  busy,  input  valid, input  result);
  modport slave  (input  start, input  abort, input  sn_in,
                  output busy,  output valid, output result);
endinterface

// File: rtl/sn_to_bin.sv
// Stochastic-to-binary decoder: counts ones of sn_in over a 2^WIDTH-cycle window.
// Optional macro SN_BIPOLAR_EN selects a saturated two's-complement bipolar result.
module sn_to_bin #(
  parameter int WIDTH = 7
) (
  input logic         clk,
  input logic         rst,
  sn_to_bin_if.slave  bus
);

  typedef enum logic {S_IDLE, S_COUNT} state_t;

  state_t         r_state;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH:0]   r_acc;
  logic             r_busy;
  logic             r_valid;
  logic [WIDTH:0]   r_result;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_res;

  assign w_sum = r_acc + {{WIDTH{1'b0}}, bus.sn_in};

`ifdef SN_BIPOLAR_EN
  logic [WIDTH+1:0] w_bi;
  // 2*ones - 2^WIDTH; the single out-of-range value (+2^WIDTH) clamps to max positive
  assign w_bi  = {w_sum, 1'b0} - (WIDTH+2)'(1 << WIDTH);
  assign w_res = (w_sum == (WIDTH+1)'(1 << WIDTH)) ? (WIDTH+1)'((1 << WIDTH) - 1)
                                                   : w_bi[WIDTH:0];
`else
  assign w_res = w_sum;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_busy   <= 1'b0;
      r_valid  <= 1'b0;
      r_result <= '0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_cnt   <= '0;
            r_acc   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_COUNT;
          end
        end
        S_COUNT: begin
          if (bus.abort) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (r_cnt == {WIDTH{1'b1}}) begin
            r_result <= w_res;
            r_valid  <= 1'b1;
            r_busy   <= 1'b0;
            r_cnt    <= '0;
            r_state  <= S_IDLE;
          end else begin
            r_acc <= w_sum;
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy   = r_busy;
  assign bus.valid  = r_valid;
  assign bus.result = r_result;

endmodule

// File: tb/tb_sn_to_bin.sv
// Self-checking bench for sn_to_bin: directed windows plus random streams vs. a ones-count model.
module tb_sn_to_bin;
  localparam int WIDTH = 7;
  localparam int N     = 1 << WIDTH;

  logic clk = 1'b0;
  logic rst;
  int   n_assert = 0;
  int   n_fail   = 0;
  logic [WIDTH:0] last_exp;
  logic bits [N];

  sn_to_bin_if #(.WIDTH(WIDTH)) bus ();
  sn_to_bin #(.WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference decode straight from the definition: count, then map to the output format.
  function automatic logic [WIDTH:0] model(input int ones);
    int v;
`ifdef SN_BIPOLAR_EN
    v = 2 * ones - N;
    if (v > N - 1) v = N - 1;
`else
    v = ones;
`endif
    return v[WIDTH:0];
  endfunction

  task automatic fill(input int mode);
    for (int i = 0; i < N; i++)
      case (mode)
        0: bits[i] = 1'b0;
        1: bits[i] = 1'b1;
        2: bits[i] = (i % 2 == 0);
        default: bits[i] = 1'($urandom_range(0, 1));
      endcase
  endtask

  // Runs one window over bits[]; optional abort at sample abort_at, stray start at restart_at.
  task automatic do_window(input string tag, input int abort_at, input int restart_at);
    int ones = 0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check({tag, "_busy_start"}, 32'(bus.busy), 32'd1);
    for (int i = 0; i < N; i++) begin
      bus.sn_in = bits[i];
      bus.start = (i == restart_at);
      bus.abort = (i == abort_at);
      ones += int'(bits[i]);
      @(negedge clk);
      bus.start = 1'b0;
      if (i == abort_at) begin
        bus.abort = 1'b0;
        check({tag, "_abort_busy"},   32'(bus.busy),   32'd0);
        check({tag, "_abort_valid"},  32'(bus.valid),  32'd0);
        check({tag, "_abort_result"}, 32'(bus.result), 32'(last_exp));
        repeat (3) @(negedge clk);
        check({tag, "_abort_novalid"}, 32'(bus.valid), 32'd0);
        return;
      end
      if (i < N - 1 && bus.valid !== 1'b0) check({tag, "_early_valid"}, 32'(bus.valid), 32'd0);
      if (i < N - 1 && bus.busy  !== 1'b1) check({tag, "_busy_mid"},   32'(bus.busy),  32'd1);
    end
    last_exp = model(ones);
    check({tag, "_valid"},  32'(bus.valid),  32'd1);
    check({tag, "_result"}, 32'(bus.result), 32'(last_exp));
    check({tag, "_busy_end"}, 32'(bus.busy), 32'd0);
    @(negedge clk);
    check({tag, "_valid_pulse"}, 32'(bus.valid), 32'd0);
    check({tag, "_result_hold"}, 32'(bus.result), 32'(last_exp));
  endtask

  initial begin
    int vcnt;
    int vt [2];
    logic [WIDTH:0] vr [2];

    rst = 1'b1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.sn_in = 1'b0;
    last_exp  = '0;
    repeat (3) @(negedge clk);
    check("rst_busy",   32'(bus.busy),   32'd0);
    check("rst_valid",  32'(bus.valid),  32'd0);
    check("rst_result", 32'(bus.result), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    fill(1); do_window("ones", -1, -1);
    fill(0); do_window("zeros", -1, -1);
    fill(2); do_window("alt", -1, -1);
    fill(2); do_window("alt_restart", -1, 10);
    for (int k = 0; k < 4; k++) begin
      fill(3); do_window("rand", -1, -1);
    end
    fill(3); do_window("abort50", 50, -1);
    // abort on the last sample edge beats the completion
    fill(1); do_window("abort_last", N - 1, -1);
    fill(1); do_window("ones_again", -1, -1);

    // async reset in the middle of a window
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 30; i++) begin
      bus.sn_in = 1'b1;
      @(negedge clk);
    end
    #2 rst = 1'b1;
    #1;
    check("midrst_busy",   32'(bus.busy),   32'd0);
    check("midrst_valid",  32'(bus.valid),  32'd0);
    check("midrst_result", 32'(bus.result), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // start held high: window 1 samples edges 1..N, restart on edge N+1, window 2 samples N+2..2N+1
    vcnt = 0;
    bus.start = 1'b1;
    @(negedge clk);
    for (int k = 1; k <= 2 * N + 20; k++) begin
      bus.sn_in = (k <= N + 1);
      @(negedge clk);
      if (bus.valid === 1'b1) begin
        if (vcnt < 2) begin
          vt[vcnt] = k;
          vr[vcnt] = bus.result;
        end
        vcnt++;
      end
    end
    bus.start = 1'b0;
    check("b2b_count", 32'(vcnt), 32'd2);
    if (vcnt >= 2) begin
      check("b2b_first_at", 32'(vt[0]), 32'(N));
      check("b2b_spacing",  32'(vt[1] - vt[0]), 32'(N + 1));
      check("b2b_res1",     32'(vr[0]), 32'(model(N)));
      check("b2b_res2",     32'(vr[1]), 32'(model(0)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
